// File: rtl/rv_scoreboard_pkg.sv
// Shared scoreboard constants and the decoder-to-hazard issue bundle.
// No logic, so no latency and no backpressure.
package rv_scoreboard_pkg;

    localparam int SB_NREG       = 32;
    localparam int SB_MAX_LAT    = 4;
    localparam int SB_COMMIT_LAT = 1;
    localparam int SB_RW         = $clog2(SB_NREG);
    localparam int SB_LW         = $clog2(SB_MAX_LAT + 1);

    typedef struct packed {
        logic             valid;
        logic [SB_RW-1:0] rs1;
        logic             rs1_use;
        logic [SB_RW-1:0] rs2;
        logic             rs2_use;
        logic [SB_RW-1:0] rd;
        logic             rd_we;
        logic [SB_LW-1:0] lat;
    } sb_issue_t;

endpackage

// File: rtl/rv_scoreboard_if.sv
// Issue/flush request from decode and the hazard view back from the scoreboard.
// Pure wiring; stall is the only backpressure and is combinational.
interface rv_scoreboard_if
    import rv_scoreboard_pkg::*;
#(
    parameter int NREG    = SB_NREG,
    parameter int MAX_LAT = SB_MAX_LAT
) ();

    localparam int RW = $clog2(NREG);
    localparam int LW = $clog2(MAX_LAT + 1);

    logic          issue_valid;
    logic [RW-1:0] issue_rs1;
    logic          issue_rs1_use;
    logic [RW-1:0] issue_rs2;
    logic          issue_rs2_use;
    logic [RW-1:0] issue_rd;
    logic          issue_rd_we;
    logic [LW-1:0] issue_lat;
    logic          flush;
    logic          stall;
    logic          issue_fire;
    logic [NREG-1:0] busy_vec;
    logic [RW:0]   busy_cnt;

    modport master (
        output issue_valid, issue_rs1, issue_rs1_use, issue_rs2, issue_rs2_use,
        output issue_rd, issue_rd_we, issue_lat, flush,
        input  stall, issue_fire, busy_vec, busy_cnt
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs1_use, issue_rs2, issue_rs2_use,
        input  issue_rd, issue_rd_we, issue_lat, flush,
        output stall, issue_fire, busy_vec, busy_cnt
    );

endinterface

// File: rtl/rv_sb_entry.sv
// One destination-register pending counter: load, saturating decrement, flush-clear.
// Updates every clock; no handshake.
module rv_sb_entry #(
    parameter int LW         = 3,
    parameter int COMMIT_LAT = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          load,
    input  logic [LW-1:0] load_val,
    input  logic          flush,
    output logic [LW-1:0] cnt,
    output logic          busy
);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt <= '0;
        end else if (flush && (cnt > LW'(COMMIT_LAT))) begin
            // still speculative: the producer is squashed
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - LW'(1);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/rv_scoreboard.sv
// Register scoreboard: RAW/WAW issue stall with per-register writeback down-counters.
// stall/issue_fire are combinational; counters and busy views update on the next edge.
module rv_scoreboard
    import rv_scoreboard_pkg::*;
#(
    parameter int NREG       = SB_NREG,
    parameter int MAX_LAT    = SB_MAX_LAT,
    parameter int COMMIT_LAT = SB_COMMIT_LAT
) (
    input logic           CLK,
    input logic           RST,
    rv_scoreboard_if.slave sb
);

    localparam int RW = $clog2(NREG);
    localparam int LW = $clog2(MAX_LAT + 1);

    logic [NREG-1:0][LW-1:0] cnt;
    logic [NREG-1:0]         busy;
    logic [LW-1:0]           lat_c;
    logic                    raw_hit;
    logic                    waw_hit;
    logic                    stall;
    logic                    fire;
    logic                    load_en;
    logic [RW:0]             pop;

    assign cnt[0]  = '0;
    assign busy[0] = 1'b0;

    assign lat_c = (sb.issue_lat > LW'(MAX_LAT)) ? LW'(MAX_LAT) : sb.issue_lat;

    // x0 has a constant zero counter, so index 0 can never hit either check.
    assign raw_hit = (sb.issue_rs1_use && (cnt[sb.issue_rs1] != '0)) ||
                     (sb.issue_rs2_use && (cnt[sb.issue_rs2] != '0));
    assign waw_hit = sb.issue_rd_we && (sb.issue_rd != '0) && (cnt[sb.issue_rd] > lat_c);

    assign stall   = sb.issue_valid && (raw_hit || waw_hit);
    assign fire    = sb.issue_valid && !stall && !sb.flush;
    assign load_en = fire && sb.issue_rd_we && (sb.issue_rd != '0) && (lat_c != '0);

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        rv_sb_entry #(
            .LW         (LW),
            .COMMIT_LAT (COMMIT_LAT)
        ) u_entry (
            .CLK      (CLK),
            .RST      (RST),
            .load     (load_en && (sb.issue_rd == RW'(r))),
            .load_val (lat_c),
            .flush    (sb.flush),
            .cnt      (cnt[r]),
            .busy     (busy[r])
        );
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NREG; i++) begin
            pop = pop + (RW+1)'(busy[i]);
        end
    end

    assign sb.stall      = stall;
    assign sb.issue_fire = fire;
    assign sb.busy_vec   = busy;
    assign sb.busy_cnt   = pop;

endmodule

// File: tb/tb_rv_scoreboard.sv
// Scoreboard bench: directed scenarios with literal expectations plus random traffic
// checked every cycle against a ready-time model.
module tb_rv_scoreboard;
    import rv_scoreboard_pkg::*;

    localparam int NREG       = SB_NREG;
    localparam int MAX_LAT    = SB_MAX_LAT;
    localparam int COMMIT_LAT = SB_COMMIT_LAT;
    localparam int RW         = SB_RW;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    rv_scoreboard_if #(.NREG(NREG), .MAX_LAT(MAX_LAT)) sb ();

    rv_scoreboard #(
        .NREG       (NREG),
        .MAX_LAT    (MAX_LAT),
        .COMMIT_LAT (COMMIT_LAT)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .sb  (sb)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic sb_issue_t mk(input logic v, input int rs1, input logic u1,
                                     input int rs2, input logic u2, input int rd,
                                     input logic we, input int lat);
        sb_issue_t t;
        t.valid   = v;
        t.rs1     = SB_RW'(rs1);
        t.rs1_use = u1;
        t.rs2     = SB_RW'(rs2);
        t.rs2_use = u2;
        t.rd      = SB_RW'(rd);
        t.rd_we   = we;
        t.lat     = SB_LW'(lat);
        return t;
    endfunction

    task automatic drive(input sb_issue_t t, input logic fl);
        sb.issue_valid   = t.valid;
        sb.issue_rs1     = t.rs1;
        sb.issue_rs1_use = t.rs1_use;
        sb.issue_rs2     = t.rs2;
        sb.issue_rs2_use = t.rs2_use;
        sb.issue_rd      = t.rd;
        sb.issue_rd_we   = t.rd_we;
        sb.issue_lat     = t.lat;
        sb.flush         = fl;
    endtask

    task automatic idle();
        drive(mk(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0), 1'b0);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Model: each register holds the absolute cycle at which its value becomes
    // readable; anything at or before the current cycle is simply not pending.
    longint avail [NREG];
    longint cyc   = 0;
    bit     armed = 1'b0;

    function automatic int rem(input int r);
        if (r == 0 || avail[r] <= cyc) return 0;
        return int'(avail[r] - cyc);
    endfunction

    always @(negedge CLK) begin
        logic            e_stall;
        logic            e_fire;
        logic [NREG-1:0] e_vec;
        int              e_cnt;
        int              rs1, rs2, rd, lat;

        rs1 = int'(sb.issue_rs1);
        rs2 = int'(sb.issue_rs2);
        rd  = int'(sb.issue_rd);
        lat = int'(sb.issue_lat);
        e_stall = sb.issue_valid &&
                  ((sb.issue_rs1_use && rem(rs1) > 0) ||
                   (sb.issue_rs2_use && rem(rs2) > 0) ||
                   (sb.issue_rd_we && rd != 0 && rem(rd) > lat));
        e_fire = sb.issue_valid && !e_stall && !sb.flush;
        e_cnt  = 0;
        for (int r = 0; r < NREG; r++) begin
            e_vec[r] = (rem(r) > 0);
            e_cnt += (rem(r) > 0) ? 1 : 0;
        end

        if (armed) begin
            chk("stall", sb.stall, e_stall);
            chk("issue_fire", sb.issue_fire, e_fire);
            chk("busy_vec", sb.busy_vec, e_vec);
            chk("busy_cnt", sb.busy_cnt, e_cnt);
        end

        if (RST === 1'b0) begin
            for (int r = 0; r < NREG; r++) avail[r] = 0;
            armed = 1'b1;
        end else if (sb.flush) begin
            for (int r = 0; r < NREG; r++)
                if (rem(r) > COMMIT_LAT) avail[r] = 0;
        end else if (e_fire && sb.issue_rd_we && rd != 0 && lat != 0) begin
            avail[rd] = cyc + 1 + ((lat > MAX_LAT) ? MAX_LAT : lat);
        end
        cyc++;
    end

    int seq6 [8] = '{1, 2, 3, 4, 3, 2, 1, 0};

    initial begin
        sb_issue_t t;

        // Reset held two cycles with a would-be issue on the bus
        RST = 1'b0;
        drive(mk(1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1, 3), 1'b0);
        tick();
        tick();
        RST = 1'b1;
        idle();
        @(negedge CLK);
        chk("rst_busy_vec", sb.busy_vec, 0);
        chk("rst_busy_cnt", sb.busy_cnt, 0);
        chk("rst_stall", sb.stall, 0);
        tick();

        // RAW: producer x5 lat 3, consumer reads x5 from the next cycle
        drive(mk(1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1, 3), 1'b0);
        @(negedge CLK);
        chk("raw_prod_fire", sb.issue_fire, 1);
        tick();
        drive(mk(1'b1, 5, 1'b1, 0, 1'b0, 0, 1'b0, 0), 1'b0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLK);
            chk("raw_stall", sb.stall, 1);
            tick();
        end
        @(negedge CLK);
        chk("raw_fire", sb.issue_fire, 1);
        chk("raw_busy5", sb.busy_vec[5], 0);
        tick();
        idle();
        tick();

        // WAW: x7 lat 4 then x7 lat 1 must wait until remaining count <= 1
        drive(mk(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 4), 1'b0);
        @(negedge CLK);
        chk("waw_first_fire", sb.issue_fire, 1);
        tick();
        drive(mk(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 1), 1'b0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLK);
            chk("waw_stall", sb.stall, 1);
            tick();
        end
        @(negedge CLK);
        chk("waw_fire", sb.issue_fire, 1);
        tick();
        idle();
        @(negedge CLK);
        chk("waw_reload_busy7", sb.busy_vec[7], 1);
        tick();
        @(negedge CLK);
        chk("waw_done_busy7", sb.busy_vec[7], 0);
        tick();

        // x0 destination/source and untracked lat 0
        drive(mk(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b1, 4), 1'b0);
        tick();
        drive(mk(1'b1, 0, 1'b1, 0, 1'b1, 0, 1'b0, 0), 1'b0);
        @(negedge CLK);
        chk("x0_stall", sb.stall, 0);
        chk("x0_busy_cnt", sb.busy_cnt, 0);
        tick();
        drive(mk(1'b1, 0, 1'b0, 0, 1'b0, 3, 1'b1, 0), 1'b0);
        tick();
        drive(mk(1'b1, 3, 1'b1, 0, 1'b0, 0, 1'b0, 0), 1'b0);
        @(negedge CLK);
        chk("lat0_stall", sb.stall, 0);
        chk("lat0_busy_cnt", sb.busy_cnt, 0);
        tick();
        idle();
        tick();

        // Selective flush: x6 at 1 (committed), x4 at 3 (speculative)
        drive(mk(1'b1, 0, 1'b0, 0, 1'b0, 6, 1'b1, 2), 1'b0);
        tick();
        drive(mk(1'b1, 0, 1'b0, 0, 1'b0, 4, 1'b1, 3), 1'b0);
        tick();
        drive(mk(1'b1, 0, 1'b0, 0, 1'b0, 8, 1'b1, 2), 1'b1);
        @(negedge CLK);
        chk("flush_fire", sb.issue_fire, 0);
        chk("flush_pre_cnt", sb.busy_cnt, 2);
        tick();
        idle();
        @(negedge CLK);
        chk("flush_post_cnt", sb.busy_cnt, 0);
        tick();

        // Back-to-back independent producers x1..x4 lat 4
        for (int i = 0; i < 9; i++) begin
            if (i < 4) drive(mk(1'b1, 0, 1'b0, 0, 1'b0, i + 1, 1'b1, 4), 1'b0);
            else       idle();
            @(negedge CLK);
            if (i < 4) chk("b2b_stall", sb.stall, 0);
            if (i > 0) chk("b2b_busy_cnt", sb.busy_cnt, seq6[i-1]);
            tick();
        end

        // Oversized latency clamps to MAX_LAT
        drive(mk(1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b1, 7), 1'b0);
        tick();
        idle();
        repeat (3) tick();
        @(negedge CLK);
        chk("clamp_last_busy", sb.busy_vec[9], 1);
        tick();
        @(negedge CLK);
        chk("clamp_clear", sb.busy_vec[9], 0);
        tick();

        // Random traffic over a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            RST       = ($urandom_range(0, 199) != 0);
            t.valid   = ($urandom_range(0, 3) != 0);
            t.rs1     = SB_RW'($urandom_range(0, 7));
            t.rs1_use = 1'($urandom_range(0, 1));
            t.rs2     = SB_RW'($urandom_range(0, 7));
            t.rs2_use = 1'($urandom_range(0, 1));
            t.rd      = SB_RW'($urandom_range(0, 7));
            t.rd_we   = ($urandom_range(0, 3) != 0);
            t.lat     = SB_LW'($urandom_range(0, 7));
            drive(t, ($urandom_range(0, 15) == 0));
            tick();
        end

        RST = 1'b1;
        idle();
        repeat (6) tick();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
